// File: rtl/ram_sweep_pkg.sv
// Shared types and helpers for the RAM sweep controller: FSM state encoding,
// address-width calculation and RAM output-mode read latency.
package ram_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        PLAY,
        FLUSH,
        BIST_WR,
        BIST_RD
    } state_t;

    // Number of bits needed to represent the value 'depth'.
    function automatic int clogb2(input int depth);
        int d;
        int w;
        d = depth;
        for (w = 0; d > 0; w++) begin
            d = d >> 1;
        end
        return w;
    endfunction

    // The registered output stage adds one cycle over the raw array read.
    function automatic int ram_lat(input logic [127:0] perf);
        return (perf == {40'd0, "LOW_LATENCY"}) ? 1 : 2;
    endfunction

endpackage

// File: rtl/ram_rd_valid_pipe.sv
// LAT-deep shift register carrying {issued, is_last} alongside RAM reads so
// the flags emerge in the same cycle as the matching read data.
module ram_rd_valid_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last,
    output logic empty
);

    logic [LAT-1:0] v;
    logic [LAT-1:0] l;

    // Shift the read flags one stage per clock; clr empties the pipe.
    always_ff @(posedge clk) begin
        if (clr) begin
            v <= '0;
            l <= '0;
        end else begin
            v[0] <= in_valid;
            l[0] <= in_last;
            for (int unsigned i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                l[i] <= l[i-1];
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_last  = l[LAT-1];
    assign empty     = ~|v;

endmodule

// File: rtl/ram_sweep_ctrl.sv
// Port-A master for a single-port no-change block RAM: captures a sample
// stream into addresses 0..last_addr, then plays it back with valid/last
// aligned to the RAM read latency.
// Optional build macro RAM_SWEEP_CTRL_BIST_EN adds an address-pattern
// write/read-back self test with sticky error flag and saturating counter.
module ram_sweep_ctrl
    import ram_sweep_pkg::*;
#(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int ADDR_W         = clogb2(RAM_DEPTH-1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_start,
    input  logic                 play_start,
    input  logic [ADDR_W-1:0]    last_addr,
    input  logic [RAM_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic                 ram_rsta,
    output logic                 ram_regcea,
    output logic [ADDR_W-1:0]    ram_addra,
    output logic [RAM_WIDTH-1:0] ram_dina,
    input  logic [RAM_WIDTH-1:0] ram_douta
`ifdef RAM_SWEEP_CTRL_BIST_EN
    ,
    input  logic                 bist_start,
    output logic                 bist_err,
    output logic [15:0]          bist_err_cnt
`endif
);

    localparam int LAT = ram_lat(RAM_PERFORMANCE);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(RAM_DEPTH-1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, last_r, last_clamped;
    logic              at_last, start, addr_clr, addr_inc;
    logic              rd_issue, done_set, done_r, pipe_empty;

`ifdef RAM_SWEEP_CTRL_BIST_EN
    logic              bist_go, rd_all;
    logic [ADDR_W-1:0] exp_addr;
`endif

    assign at_last      = (addr == last_r);
    assign last_clamped = (last_addr > MAX_ADDR) ? MAX_ADDR : last_addr;

    // Next-state and RAM port decode.
    always_comb begin
        state_next = state;
        ram_ena    = 1'b0;
        ram_wea    = 1'b0;
        ram_dina   = s_data;
        rd_issue   = 1'b0;
        addr_inc   = 1'b0;
        addr_clr   = 1'b0;
        start      = 1'b0;
        done_set   = 1'b0;
`ifdef RAM_SWEEP_CTRL_BIST_EN
        bist_go    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cap_start) begin
                    state_next = CAPTURE;
                    start      = 1'b1;
                end else if (play_start) begin
                    state_next = PLAY;
                    start      = 1'b1;
`ifdef RAM_SWEEP_CTRL_BIST_EN
                end else if (bist_start) begin
                    state_next = BIST_WR;
                    start      = 1'b1;
                    bist_go    = 1'b1;
`endif
                end
                addr_clr = start;
            end
            CAPTURE: begin
                ram_ena = s_valid;
                ram_wea = s_valid;
                if (s_valid) begin
                    if (at_last) begin
                        state_next = IDLE;
                        done_set   = 1'b1;
                    end else begin
                        addr_inc = 1'b1;
                    end
                end
            end
            PLAY: begin
                ram_ena  = 1'b1;
                rd_issue = 1'b1;
                if (at_last) state_next = FLUSH;
                else         addr_inc   = 1'b1;
            end
            FLUSH: begin
                if (pipe_empty) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
`ifdef RAM_SWEEP_CTRL_BIST_EN
            BIST_WR: begin
                ram_ena  = 1'b1;
                ram_wea  = 1'b1;
                ram_dina = RAM_WIDTH'(addr);
                if (at_last) begin
                    state_next = BIST_RD;
                    addr_clr   = 1'b1;
                end else begin
                    addr_inc = 1'b1;
                end
            end
            BIST_RD: begin
                if (!rd_all) begin
                    ram_ena  = 1'b1;
                    rd_issue = 1'b1;
                    if (!at_last) addr_inc = 1'b1;
                end
                if (m_valid && m_last) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State, sweep address and done-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= '0;
            last_r <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= done_set;
            if (start) last_r <= last_clamped;
            if (addr_clr)      addr <= '0;
            else if (addr_inc) addr <= addr + 1'b1;
        end
    end

    ram_rd_valid_pipe #(
        .LAT(LAT)
    ) u_pipe (
        .clk      (clk),
        .clr      (rst),
        .in_valid (rd_issue),
        .in_last  (rd_issue && at_last),
        .out_valid(m_valid),
        .out_last (m_last),
        .empty    (pipe_empty)
    );

`ifdef RAM_SWEEP_CTRL_BIST_EN
    // Read-back compare: words return in issue order, so a running expected
    // address paired with the read pipe tail lines up with each data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_all       <= 1'b0;
            exp_addr     <= '0;
            bist_err     <= 1'b0;
            bist_err_cnt <= '0;
        end else if (bist_go) begin
            rd_all       <= 1'b0;
            exp_addr     <= '0;
            bist_err     <= 1'b0;
            bist_err_cnt <= '0;
        end else if (state == BIST_RD) begin
            if (rd_issue && at_last) rd_all <= 1'b1;
            if (m_valid) begin
                exp_addr <= exp_addr + 1'b1;
                if (ram_douta != RAM_WIDTH'(exp_addr)) begin
                    bist_err <= 1'b1;
                    if (bist_err_cnt != '1) bist_err_cnt <= bist_err_cnt + 1'b1;
                end
            end
        end
    end
`endif

    assign ram_rsta   = rst;
    assign ram_regcea = 1'b1;
    assign ram_addra  = addr;
    assign m_data     = ram_douta;
    assign busy       = (state != IDLE);
    assign done       = done_r;

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Self-checking bench for ram_sweep_ctrl: one HIGH_PERFORMANCE and one
// LOW_LATENCY instance, each with a behavioural no-change RAM model.
module tb_ram_sweep_ctrl;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct { logic [9:0] a; logic [17:0] d; } wr_t;
    typedef struct { logic [17:0] d; logic l; int due; } rd_t;

    wr_t wq[$];
    rd_t rq[$];

    logic [17:0] ref_mem [1024];
    logic [17:0] ref_l   [1024];
    logic [17:0] mem_h   [1024];
    logic [17:0] mem_l   [1024];
    logic        fault_en;

    // HIGH_PERFORMANCE instance signals
    logic        h_cap_start, h_play_start, h_s_valid;
    logic [9:0]  h_last_addr, h_ram_addra;
    logic [17:0] h_s_data, h_m_data, h_ram_dina, h_douta, h_ram_q;
    logic        h_m_valid, h_m_last, h_busy, h_done;
    logic        h_ram_ena, h_ram_wea, h_ram_rsta, h_ram_regcea;

    // LOW_LATENCY instance signals
    logic        l_cap_start, l_play_start, l_s_valid;
    logic [9:0]  l_last_addr, l_ram_addra;
    logic [17:0] l_s_data, l_m_data, l_ram_dina, l_ram_q;
    logic        l_m_valid, l_m_last, l_busy, l_done;
    logic        l_ram_ena, l_ram_wea, l_ram_rsta, l_ram_regcea;

`ifdef RAM_SWEEP_CTRL_BIST_EN
    logic        h_bist_start, h_bist_err, l_bist_start, l_bist_err;
    logic [15:0] h_bist_err_cnt, l_bist_err_cnt;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_sweep_ctrl #(
        .RAM_WIDTH(18), .RAM_DEPTH(1024), .RAM_PERFORMANCE("HIGH_PERFORMANCE")
    ) u_hp (
        .clk(clk), .rst(rst), .cap_start(h_cap_start), .play_start(h_play_start),
        .last_addr(h_last_addr), .s_data(h_s_data), .s_valid(h_s_valid),
        .m_data(h_m_data), .m_valid(h_m_valid), .m_last(h_m_last),
        .busy(h_busy), .done(h_done), .ram_ena(h_ram_ena), .ram_wea(h_ram_wea),
        .ram_rsta(h_ram_rsta), .ram_regcea(h_ram_regcea), .ram_addra(h_ram_addra),
        .ram_dina(h_ram_dina), .ram_douta(h_douta)
`ifdef RAM_SWEEP_CTRL_BIST_EN
        , .bist_start(h_bist_start), .bist_err(h_bist_err), .bist_err_cnt(h_bist_err_cnt)
`endif
    );

    ram_sweep_ctrl #(
        .RAM_WIDTH(18), .RAM_DEPTH(1024), .RAM_PERFORMANCE("LOW_LATENCY")
    ) u_ll (
        .clk(clk), .rst(rst), .cap_start(l_cap_start), .play_start(l_play_start),
        .last_addr(l_last_addr), .s_data(l_s_data), .s_valid(l_s_valid),
        .m_data(l_m_data), .m_valid(l_m_valid), .m_last(l_m_last),
        .busy(l_busy), .done(l_done), .ram_ena(l_ram_ena), .ram_wea(l_ram_wea),
        .ram_rsta(l_ram_rsta), .ram_regcea(l_ram_regcea), .ram_addra(l_ram_addra),
        .ram_dina(l_ram_dina), .ram_douta(l_ram_q)
`ifdef RAM_SWEEP_CTRL_BIST_EN
        , .bist_start(l_bist_start), .bist_err(l_bist_err), .bist_err_cnt(l_bist_err_cnt)
`endif
    );

    // No-change RAM with output register (read latency 2); optional bit0 fault at address 5.
    always @(posedge clk) begin
        if (h_ram_ena) begin
            if (h_ram_wea) mem_h[h_ram_addra] <= h_ram_dina;
            else h_ram_q <= mem_h[h_ram_addra] ^ {17'd0, (fault_en && h_ram_addra == 10'd5)};
        end
        if (h_ram_rsta)        h_douta <= '0;
        else if (h_ram_regcea) h_douta <= h_ram_q;
    end

    // Read-only RAM without output register (read latency 1).
    always @(posedge clk) begin
        if (l_ram_rsta)                   l_ram_q <= '0;
        else if (l_ram_ena && !l_ram_wea) l_ram_q <= mem_l[l_ram_addra];
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (h_busy !== 1'b0 || h_done !== 1'b0 || h_m_valid !== 1'b0 || h_m_last !== 1'b0)
            begin errors++; $display("FAIL rst_status: got busy=%b done=%b mv=%b ml=%b want 0000", h_busy, h_done, h_m_valid, h_m_last); end
        checks++;
        if (h_ram_rsta !== 1'b1 || h_ram_regcea !== 1'b1 || h_ram_ena !== 1'b0 || h_ram_wea !== 1'b0)
            begin errors++; $display("FAIL rst_ramctl: got rsta=%b regcea=%b ena=%b wea=%b want 1100", h_ram_rsta, h_ram_regcea, h_ram_ena, h_ram_wea); end
        checks++;
        if (h_ram_addra !== 10'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", h_ram_addra); end
        checks++;
        if (l_busy !== 1'b0 || l_done !== 1'b0 || l_m_valid !== 1'b0)
            begin errors++; $display("FAIL rst_ll_status: got busy=%b done=%b mv=%b want 000", l_busy, l_done, l_m_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (h_ram_rsta !== 1'b0 || h_busy !== 1'b0)
            begin errors++; $display("FAIL rst_release: got rsta=%b busy=%b want 0 0", h_ram_rsta, h_busy); end
        @(posedge clk); #1;
    endtask

    // Pops one write from the scoreboard and compares it against the RAM port.
    task automatic check_write_port(input string tag);
        wr_t w;
        checks++;
        if (wq.size() == 0) begin
            errors++; $display("FAIL %s_extra_write: got addr %0d want no write", tag, h_ram_addra);
        end else begin
            w = wq.pop_front();
            if (h_ram_addra !== w.a || h_ram_dina !== w.d || h_ram_ena !== 1'b1) begin
                errors++;
                $display("FAIL %s_write: got addr %0d data %0h ena %b want addr %0d data %0h ena 1",
                         tag, h_ram_addra, h_ram_dina, h_ram_ena, w.a, w.d);
            end
        end
    endtask

    task automatic test_capture();
        int writes;
        writes = 0;
        wq.delete();
        @(posedge clk); #1;
        h_last_addr = 10'd1023; h_cap_start = 1'b1;
        @(posedge clk); #1;
        h_cap_start = 1'b0;
        for (int i = 0; i < 1030; i++) begin
            if (i < 1024) begin
                h_s_valid = 1'b1; h_s_data = 18'(i);
                wq.push_back('{a: 10'(i), d: 18'(i)});
                ref_mem[i] = 18'(i);
            end else begin
                h_s_valid = 1'b0;
            end
            @(negedge clk);
            if (h_ram_wea) begin
                writes++;
                check_write_port("cap");
            end
            checks++;
            if (h_done !== (i == 1024)) begin errors++; $display("FAIL cap_done: cycle %0d got %b want %b", i, h_done, (i == 1024)); end
            if (i == 1024) begin
                checks++;
                if (h_busy !== 1'b0) begin errors++; $display("FAIL cap_busy_after: got %b want 0", h_busy); end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (writes != 1024 || wq.size() != 0) begin errors++; $display("FAIL cap_count: got %0d writes want 1024", writes); end
    endtask

    task automatic test_gapped_capture();
        int writes;
        writes = 0;
        wq.delete();
        @(posedge clk); #1;
        h_last_addr = 10'd7; h_cap_start = 1'b1;
        @(posedge clk); #1;
        h_cap_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16 && (i % 2) == 0) begin
                h_s_valid = 1'b1; h_s_data = 18'(200 + i);
                wq.push_back('{a: 10'(i / 2), d: 18'(200 + i)});
                ref_mem[i / 2] = 18'(200 + i);
            end else begin
                h_s_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 15) begin
                checks++;
                if (h_ram_addra !== 10'((i + 1) / 2)) begin errors++; $display("FAIL gap_addr: cycle %0d got %0d want %0d", i, h_ram_addra, (i + 1) / 2); end
                checks++;
                if (h_ram_wea !== h_s_valid) begin errors++; $display("FAIL gap_wea: cycle %0d got %b want %b", i, h_ram_wea, h_s_valid); end
            end
            if (h_ram_wea) begin
                writes++;
                check_write_port("gap");
            end
            checks++;
            if (h_done !== (i == 15)) begin errors++; $display("FAIL gap_done: cycle %0d got %b want %b", i, h_done, (i == 15)); end
            @(posedge clk); #1;
        end
        checks++;
        if (writes != 8 || wq.size() != 0) begin errors++; $display("FAIL gap_count: got %0d writes want 8", writes); end
    endtask

    // Plays 0..last on the selected instance and scores every returned word.
    task automatic run_play(input bit ll, input int last, input int lat, input string tag);
        int k, done_c, done_n;
        logic ena, wea, mv, ml, dn, bz;
        logic [9:0]  addra;
        logic [17:0] md;
        rd_t r;
        k = 0; done_c = -1; done_n = 0;
        rq.delete();
        @(posedge clk); #1;
        if (ll) begin l_last_addr = 10'(last); l_play_start = 1'b1; end
        else    begin h_last_addr = 10'(last); h_play_start = 1'b1; end
        @(posedge clk); #1;
        l_play_start = 1'b0; h_play_start = 1'b0;
        for (int c = 0; c < last + lat + 6; c++) begin
            @(negedge clk);
            ena   = ll ? l_ram_ena   : h_ram_ena;
            wea   = ll ? l_ram_wea   : h_ram_wea;
            addra = ll ? l_ram_addra : h_ram_addra;
            mv    = ll ? l_m_valid   : h_m_valid;
            ml    = ll ? l_m_last    : h_m_last;
            md    = ll ? l_m_data    : h_m_data;
            dn    = ll ? l_done      : h_done;
            if (wea) begin checks++; errors++; $display("FAIL %s_wea: cycle %0d got 1 want 0", tag, c); end
            if (ena && !wea) begin
                checks++;
                if (k > last || addra !== 10'(k)) begin
                    errors++; $display("FAIL %s_read_addr: cycle %0d got %0d want %0d", tag, c, addra, k);
                end else begin
                    rq.push_back('{d: (ll ? ref_l[k] : ref_mem[k]), l: (k == last), due: c + lat});
                end
                if (k == 0) begin
                    checks++;
                    if (c != 0) begin errors++; $display("FAIL %s_first_issue: got cycle %0d want 0", tag, c); end
                end
                k++;
            end
            if (mv) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++; $display("FAIL %s_extra_valid: cycle %0d got data %0h want none", tag, c, md);
                end else begin
                    r = rq.pop_front();
                    if (r.due != c || md !== r.d || ml !== r.l) begin
                        errors++;
                        $display("FAIL %s_rdata: cycle %0d got data %0h last %b want cycle %0d data %0h last %b",
                                 tag, c, md, ml, r.due, r.d, r.l);
                    end
                end
            end else if (rq.size() != 0 && rq[0].due == c) begin
                checks++; errors++;
                $display("FAIL %s_missing_valid: cycle %0d got 0 want 1", tag, c);
                void'(rq.pop_front());
            end
            if (dn) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            @(posedge clk); #1;
        end
        bz = ll ? l_busy : h_busy;
        checks++;
        if (k != last + 1 || rq.size() != 0) begin errors++; $display("FAIL %s_count: got %0d reads want %0d", tag, k, last + 1); end
        checks++;
        if (done_c != last + lat + 2 || done_n != 1) begin
            errors++; $display("FAIL %s_done: got cycle %0d pulses %0d want cycle %0d pulses 1", tag, done_c, done_n, last + lat + 2);
        end
        checks++;
        if (bz !== 1'b0) begin errors++; $display("FAIL %s_busy_after: got %b want 0", tag, bz); end
    endtask

    task automatic test_playback_hp();
        run_play(1'b0, 1023, 2, "play_hp");
    endtask

    task automatic test_low_latency();
        for (int i = 0; i < 16; i++) begin
            ref_l[i] = 18'(i * 7 + 3);
            mem_l[i] = 18'(i * 7 + 3);
        end
        run_play(1'b1, 15, 1, "play_ll");
        run_play(1'b1, 0, 1, "play_ll_one");
    endtask

    task automatic test_reset_mid_play();
        @(posedge clk); #1;
        h_last_addr = 10'd1023; h_play_start = 1'b1;
        @(posedge clk); #1;
        h_play_start = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        checks++;
        if (h_ram_addra !== 10'd300 || h_busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got addr %0d busy %b want 300 1", h_ram_addra, h_busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (h_busy !== 1'b0 || h_m_valid !== 1'b0 || h_done !== 1'b0 || h_ram_ena !== 1'b0) begin
                errors++; $display("FAIL midrst_idle: cycle %0d got busy=%b mv=%b done=%b ena=%b want 0000", i, h_busy, h_m_valid, h_done, h_ram_ena);
            end
            @(posedge clk); #1;
        end
        run_play(1'b0, 7, 2, "replay");
    endtask

    task automatic test_start_collision();
        @(posedge clk); #1;
        h_last_addr = 10'd0; h_cap_start = 1'b1; h_play_start = 1'b1; h_s_valid = 1'b0;
        @(posedge clk); #1;
        h_cap_start = 1'b0;
        @(negedge clk);
        checks++;
        if (h_busy !== 1'b1 || h_ram_ena !== 1'b0) begin errors++; $display("FAIL coll_gap: got busy=%b ena=%b want 1 0", h_busy, h_ram_ena); end
        @(posedge clk); #1;
        h_play_start = 1'b0; h_s_valid = 1'b1; h_s_data = 18'h155;
        ref_mem[0] = 18'h155;
        @(negedge clk);
        checks++;
        if (h_ram_wea !== 1'b1 || h_ram_addra !== 10'd0 || h_ram_dina !== 18'h155) begin
            errors++; $display("FAIL coll_capture: got wea=%b addr=%0d data=%0h want 1 0 155", h_ram_wea, h_ram_addra, h_ram_dina);
        end
        @(posedge clk); #1;
        h_s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (h_done !== 1'b1 || h_busy !== 1'b0) begin errors++; $display("FAIL coll_done: got done=%b busy=%b want 1 0", h_done, h_busy); end
        @(posedge clk); #1;
        run_play(1'b0, 0, 2, "coll_play");
    endtask

`ifdef RAM_SWEEP_CTRL_BIST_EN
    task automatic run_bist(input bit fault, input bit exp_err, input int exp_cnt, input string tag);
        bit seen;
        seen = 1'b0;
        fault_en = fault;
        @(posedge clk); #1;
        h_last_addr = 10'd1023; h_bist_start = 1'b1;
        @(posedge clk); #1;
        h_bist_start = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (h_done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_timeout: got no done want done", tag); end
        checks++;
        if (h_bist_err !== exp_err) begin errors++; $display("FAIL %s_err: got %b want %b", tag, h_bist_err, exp_err); end
        checks++;
        if (h_bist_err_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL %s_cnt: got %0d want %0d", tag, h_bist_err_cnt, exp_cnt); end
        @(posedge clk); #1;
        fault_en = 1'b0;
    endtask

    task automatic test_bist();
        run_bist(1'b0, 1'b0, 0, "bist_clean");
        run_bist(1'b1, 1'b1, 1, "bist_fault");
        run_bist(1'b0, 1'b0, 0, "bist_reclean");
    endtask
`endif

    initial begin
        rst = 1'b1; fault_en = 1'b0;
        h_cap_start = 1'b0; h_play_start = 1'b0; h_s_valid = 1'b0; h_s_data = '0; h_last_addr = '0;
        l_cap_start = 1'b0; l_play_start = 1'b0; l_s_valid = 1'b0; l_s_data = '0; l_last_addr = '0;
`ifdef RAM_SWEEP_CTRL_BIST_EN
        h_bist_start = 1'b0; l_bist_start = 1'b0;
`endif
        test_reset();
        test_capture();
        test_playback_hp();
        test_gapped_capture();
        test_reset_mid_play();
        test_start_collision();
        test_low_latency();
`ifdef RAM_SWEEP_CTRL_BIST_EN
        test_bist();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_sweep_ctrl.md
Name: ram_sweep_ctrl

Overview:
- Port-A master for the single-port no-change block RAM (ports clka/wea/ena/rsta/regcea/dina/addra/douta).
- Captures a sample stream into RAM at addresses 0..last_addr, then plays it back as a stream with valid/last.
- Playback valid/last are aligned to the RAM read latency.
- Sits between the DSP datapath (capture source or playback sink) and the RAM instance.

Parameters:
- RAM_WIDTH, 18, data word width.
- RAM_DEPTH, 1024, number of RAM words.
- RAM_PERFORMANCE, "HIGH_PERFORMANCE", RAM output mode. "HIGH_PERFORMANCE" gives read latency LAT=2; "LOW_LATENCY" gives LAT=1.
- ADDR_W (localparam), clogb2(RAM_DEPTH-1), address width (10 at default).

Ports:
- clk  in  1  single clock; also drives RAM clka.
- rst  in  1  synchronous active-high reset.
- cap_start  in  1  one-cycle pulse; starts capture.
- play_start  in  1  one-cycle pulse; starts playback.
- last_addr  in  ADDR_W  final address of the sweep; sampled at start.
- s_data  in  RAM_WIDTH  capture data.
- s_valid  in  1  capture data valid.
- m_data  out  RAM_WIDTH  playback data (pass-through of ram_douta).
- m_valid  out  1  playback data valid.
- m_last  out  1  marks the word read from last_addr.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse when an operation completes.
- ram_ena, ram_wea, ram_rsta, ram_regcea  out  1  RAM controls.
- ram_addra  out  ADDR_W  RAM address.
- ram_dina  out  RAM_WIDTH  RAM write data.
- ram_douta  in  RAM_WIDTH  RAM read data.

Behaviour:
- Reset values: state=IDLE, addr=0, read pipe empty, m_valid=0, m_last=0, busy=0, done=0.
- Fixed controls: ram_rsta=rst; ram_regcea=1 always.
- FSM states: IDLE, CAPTURE, PLAY, FLUSH.
- IDLE: ram_ena=0, ram_wea=0.
  - cap_start -> CAPTURE.
  - play_start -> PLAY.
  - Both pulses in the same cycle: capture wins.
  - On either start: addr<=0; last_addr latched as last_r.
  - Start pulses outside IDLE are ignored.
- CAPTURE (RAM port signals are combinational):
  - ram_ena=ram_wea=s_valid; ram_addra=addr; ram_dina=s_data.
  - s_valid=1: addr increments. s_valid=0: addr holds.
  - Accepted word at addr==last_r: -> IDLE; done pulses the following cycle.
  - m_valid stays 0; no-change mode holds douta.
- PLAY:
  - ram_ena=1, ram_wea=0, ram_addra=addr; one read issued per cycle, addr increments.
  - Read at addr==last_r: -> FLUSH.
- Read pipe: LAT-deep shift of {issued, is_last}. m_valid/m_last = pipe tail. m_data = ram_douta in the cycle m_valid=1.
- Latency: read issued in cycle t -> m_valid in cycle t+LAT.
- FLUSH: ram_ena=0. When the pipe is empty -> IDLE; done pulses the next cycle.
- Playback has no backpressure: the sink must accept every cycle.
- Word count: last_r+1 words.
  - last_addr=0: exactly one word.
  - last_addr is never compared against a value above RAM_DEPTH-1: values >= RAM_DEPTH are clamped to RAM_DEPTH-1 when latched.
  - addr never wraps past last_r.
- ram_wea is asserted only in CAPTURE.
- Reset mid-operation: next cycle is IDLE; pipe cleared; m_valid=0; no done pulse. RAM contents are not touched except the output-register reset via rsta.

Optional Feature:
- Macro: RAM_SWEEP_CTRL_BIST_EN.
- With the macro defined:
  - Added ports: bist_start in 1, bist_err out 1 (sticky), bist_err_cnt out 16 (saturating at 16'hFFFF).
  - Added states: BIST_WR writes data = address (zero-extended or truncated to RAM_WIDTH) to 0..last_r, one word per cycle. BIST_RD then reads back and compares each m_valid word to its expected address value.
  - Completion: the compare of the word carrying m_last completes the run -> IDLE, done pulse.
  - Counters: err and count clear on bist_start.
  - Priority in IDLE: cap_start > play_start > bist_start.
- Without the macro: BIST ports, states and logic are absent; behaviour is as above.

Decomposition:
- Package ram_sweep_pkg:
  - state enum (IDLE, CAPTURE, PLAY, FLUSH, BIST_WR, BIST_RD);
  - clogb2 function;
  - ram_lat function mapping RAM_PERFORMANCE to 1/2.
- Sub-module ram_rd_valid_pipe:
  - parameterised LAT-deep valid/last shift register, synchronous clear.
  - Reused by the BIST comparator alignment.

Test Plan:
- Capture: last_addr=1023, s_valid=1 for 1024 cycles with s_data=index -> 1024 ram_wea pulses, addresses 0..1023, done pulse 1 cycle after the final write, busy low afterwards.
- Gapped capture: last_addr=7, s_valid toggling 1010... -> exactly 8 writes; addr holds during gaps; done after the 8th accepted word.
- Playback latency, HIGH_PERFORMANCE, after the first test:
  - first m_valid 2 cycles after the first ram_ena read;
  - m_data=0..1023 contiguous; m_last only on 1023;
  - done 1 cycle after the FLUSH drain.
- Playback latency, LOW_LATENCY: same as above with latency 1; last_addr=0 -> single word with m_valid=m_last=1.
- Reset and start collisions:
  - rst asserted mid-PLAY at addr=300 -> IDLE next cycle, m_valid=0, no done;
  - a subsequent play_start from IDLE restarts at addr 0;
  - cap_start and play_start in the same cycle -> CAPTURE.
- BIST (RAM_SWEEP_CTRL_BIST_EN, last_addr=1023):
  - clean RAM -> bist_err=0, cnt=0;
  - force ram_douta bit0 flipped on address 5 -> bist_err=1, cnt=1.
